// File: rtl/seq_mac.sv
// ============================================================================
//  Module      : seq_mac
//  Description : Sequential shift-and-add multiplier with a running
//                accumulator. One multiplier bit is consumed per CALC cycle,
//                so latency is fixed regardless of operand values. Signed
//                operands are multiplied as magnitudes and the result is
//                negated when the operand signs differ.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NBITS    operand width (2..32)
//    ACC_EXT  accumulator guard bits above the 2*NBITS product
//  Ports
//    clk              rising-edge clock
//    rst              asynchronous active-low reset
//    i_start          request a multiplication (sampled only in IDLE)
//    i_signed_mode    1 = two's-complement operands, 0 = unsigned
//    i_acc_en         add the product into the accumulator at completion
//    i_clear_acc      synchronous clear of accumulator and overflow flag
//    i_multiplicand   operand A
//    i_multiplier     operand B
//    o_busy           high while an operation is in CALC or DONE
//    o_done           single-cycle completion pulse
//    o_product        last completed product (held until next done)
//    o_acc_out        running accumulator
//    o_overflow       sticky accumulator overflow flag
// ============================================================================
`default_nettype none

module seq_mac #(
  parameter int NBITS   = 8,
  parameter int ACC_EXT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic                         i_signed_mode,
  input  logic                         i_acc_en,
  input  logic                         i_clear_acc,
  input  logic [NBITS-1:0]             i_multiplicand,
  input  logic [NBITS-1:0]             i_multiplier,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [2*NBITS-1:0]           o_product,
  output logic [2*NBITS+ACC_EXT-1:0]   o_acc_out,
  output logic                         o_overflow
);

  localparam int c_PW    = 2 * NBITS;
  localparam int c_ACC_W = 2 * NBITS + ACC_EXT;
  localparam int c_CW    = $clog2(NBITS + 1);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_CALC = 2'd1;
  localparam logic [1:0] c_S_DONE = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]          r_state;
  logic [c_CW-1:0]     r_cnt;
  logic [c_PW-1:0]     r_mcand;     // multiplicand magnitude, shifted left each step
  logic [NBITS-1:0]    r_mplier;    // multiplier magnitude, shifted right each step
  logic [c_PW-1:0]     r_pp;        // partial product (magnitude)
  logic                r_neg;       // result must be negated
  logic                r_signed;
  logic                r_acc_en;
  logic                r_done;
  logic [c_PW-1:0]     r_product;
  logic [c_ACC_W-1:0]  r_acc;
  logic                r_ovf;

  // --------------------------------------------------------------------------
  // Operand magnitudes. Unary minus in NBITS width maps -2^(NBITS-1) onto
  // itself, which read as unsigned is exactly the required magnitude.
  // --------------------------------------------------------------------------
  logic                w_a_neg;
  logic                w_b_neg;
  logic [NBITS-1:0]    w_a_mag;
  logic [NBITS-1:0]    w_b_mag;

  assign w_a_neg = i_signed_mode & i_multiplicand[NBITS-1];
  assign w_b_neg = i_signed_mode & i_multiplier[NBITS-1];
  assign w_a_mag = w_a_neg ? -i_multiplicand : i_multiplicand;
  assign w_b_mag = w_b_neg ? -i_multiplier   : i_multiplier;

  // --------------------------------------------------------------------------
  // Multiply FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= c_S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_pp     <= '0;
      r_neg    <= 1'b0;
      r_signed <= 1'b0;
      r_acc_en <= 1'b0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (i_start) begin
            r_mcand  <= c_PW'(w_a_mag);
            r_mplier <= w_b_mag;
            r_pp     <= '0;
            r_cnt    <= c_CW'(NBITS);
            r_neg    <= w_a_neg ^ w_b_neg;
            r_signed <= i_signed_mode;
            r_acc_en <= i_acc_en;
            r_state  <= c_S_CALC;
          end
        end
        c_S_CALC: begin
          // Every bit is visited even when the remaining multiplier is zero,
          // keeping the latency independent of the operands.
          if (r_mplier[0]) begin
            r_pp <= r_pp + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - c_CW'(1);
          if (r_cnt == c_CW'(1)) begin
            r_state <= c_S_DONE;
          end
        end
        c_S_DONE: begin
          r_state <= c_S_IDLE;
        end
        default: begin
          r_state <= c_S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Result formation and accumulator arithmetic
  // --------------------------------------------------------------------------
  logic [c_PW-1:0]     w_prod_res;
  logic [c_ACC_W-1:0]  w_ext;
  logic [c_ACC_W:0]    w_sum;
  logic                w_add_ovf;
  logic                w_in_done;

  assign w_in_done  = (r_state == c_S_DONE);
  assign w_prod_res = r_neg ? -r_pp : r_pp;

  always_comb begin
    w_ext = c_ACC_W'(w_prod_res);
    if (r_signed) begin
      w_ext = c_ACC_W'($signed(w_prod_res));
    end
  end

  // One extra bit captures the unsigned carry-out.
  assign w_sum = {1'b0, r_acc} + {1'b0, w_ext};

  // Signed overflow: both addends share a sign that the result does not.
  always_comb begin
    w_add_ovf = w_sum[c_ACC_W];
    if (r_signed) begin
      w_add_ovf = (r_acc[c_ACC_W-1] == w_ext[c_ACC_W-1]) &&
                  (w_sum[c_ACC_W-1] != r_acc[c_ACC_W-1]);
    end
  end

  // --------------------------------------------------------------------------
  // Product register and done pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= w_in_done;
      if (w_in_done) begin
        r_product <= w_prod_res;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Accumulator. A clear coinciding with an accumulate loads the extended
  // product alone, i.e. the clear applies to the old value.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_in_done && r_acc_en) begin
      if (i_clear_acc) begin
        r_acc <= w_ext;
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_sum[c_ACC_W-1:0];
        r_ovf <= r_ovf | w_add_ovf;
      end
    end else if (i_clear_acc) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_busy     = (r_state != c_S_IDLE);
  assign o_done     = r_done;
  assign o_product  = r_product;
  assign o_acc_out  = r_acc;
  assign o_overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_seq_mac.sv
// ============================================================================
//  Module      : tb_seq_mac
//  Description : Self-checking bench for seq_mac (NBITS=8, ACC_EXT=4).
//                Stimulus pushes expected responses into a queue; a monitor
//                pops and compares on every done pulse.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports       : none (top-level bench)
// ============================================================================
`default_nettype none

module tb_seq_mac;

  localparam int NB = 8;
  localparam int AW = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            i_start = 1'b0;
  logic            i_signed_mode = 1'b0;
  logic            i_acc_en = 1'b0;
  logic            i_clear_acc = 1'b0;
  logic [NB-1:0]   i_multiplicand = '0;
  logic [NB-1:0]   i_multiplier = '0;
  logic            o_busy;
  logic            o_done;
  logic [2*NB-1:0] o_product;
  logic [AW-1:0]   o_acc_out;
  logic            o_overflow;

  seq_mac #(.NBITS(NB), .ACC_EXT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_signed_mode  (i_signed_mode),
    .i_acc_en       (i_acc_en),
    .i_clear_acc    (i_clear_acc),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_product      (o_product),
    .o_acc_out      (o_acc_out),
    .o_overflow     (o_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] prod;
    logic [19:0] acc;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [19:0] m_acc = '0;
  logic        m_ovf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected accumulator behaviour for one accumulate.
  function automatic void model_acc(input logic [15:0] p, input logic sgn, input logic clr);
    logic [19:0] ext;
    logic [20:0] s;
    ext = sgn ? {{4{p[15]}}, p} : {4'b0000, p};
    if (clr) begin
      m_acc = ext;
      m_ovf = 1'b0;
    end else begin
      s = {1'b0, m_acc} + {1'b0, ext};
      if (sgn) begin
        if ((m_acc[19] == ext[19]) && (s[19] != m_acc[19])) m_ovf = 1'b1;
      end else if (s[20]) begin
        m_ovf = 1'b1;
      end
      m_acc = s[19:0];
    end
  endfunction

  // Monitor: compares every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (o_done) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: done=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk("product", 32'(o_product), 32'(e.prod));
        chk("acc_out", 32'(o_acc_out), 32'(e.acc));
        chk("overflow", 32'(o_overflow), 32'(e.ovf));
        chk("done_cycle", cyc, e.cyc);
        chk("busy_at_done", 32'(o_busy), 32'd0);
      end
    end
  end

  // Issue one operation from a negedge and return on the negedge where done
  // is visible, so a following call starts back-to-back.
  task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                          input logic ae, input logic [15:0] ep,
                          input bit clr_done, input bit glitch);
    int   c;
    bit   seen;
    exp_t e;
    c = cyc;
    if (ae) model_acc(ep, sgn, clr_done);
    e.prod = ep;
    e.acc  = m_acc;
    e.ovf  = m_ovf;
    e.cyc  = c + NB + 2;
    sbq.push_back(e);
    i_multiplicand = a;
    i_multiplier   = b;
    i_signed_mode  = sgn;
    i_acc_en       = ae;
    i_start        = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_after_start", 32'(o_busy), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      i_clear_acc = clr_done && (cyc == c + 9);
      if (glitch && (cyc == c + 4)) begin
        i_start        = 1'b1;
        i_multiplicand = 8'h5A;
        i_multiplier   = 8'hC3;
        i_signed_mode  = ~sgn;
        i_acc_en       = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      if (o_done) seen = 1'b1;
    end
    i_clear_acc = 1'b0;
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: no done within 40 cycles for %h x %h", a, b);
      sbq.delete();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},     32'(o_busy),     32'd0);
    chk({tag, "_done"},     32'(o_done),     32'd0);
    chk({tag, "_product"},  32'(o_product),  32'd0);
    chk({tag, "_acc_out"},  32'(o_acc_out),  32'd0);
    chk({tag, "_overflow"}, 32'(o_overflow), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;

    // Unsigned full-scale, signed corner cases, zero operand
    drive_op(8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, 1'b0, 1'b0);
    drive_op(8'h80, 8'h80, 1'b1, 1'b0, 16'h4000, 1'b0, 1'b0);
    drive_op(8'hFD, 8'h05, 1'b1, 1'b1, 16'hFFF1, 1'b0, 1'b0);
    chk("acc_signext", 32'(o_acc_out), 32'h000FFFF1);

    // Clear while idle
    i_clear_acc = 1'b1;
    @(negedge clk);
    i_clear_acc = 1'b0;
    chk("clear_idle_acc", 32'(o_acc_out), 32'd0);
    chk("clear_idle_ovf", 32'(o_overflow), 32'd0);
    m_acc = '0;
    m_ovf = 1'b0;

    drive_op(8'h00, 8'd200, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Back-to-back accumulation
    repeat (3) drive_op(8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFE01, 1'b0, 1'b0);
    chk("acc_x3", 32'(o_acc_out), 32'h0002FA03);
    chk("ovf_x3", 32'(o_overflow), 32'd0);
    repeat (14) drive_op(8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFE01, 1'b0, 1'b0);
    chk("acc_x17", 32'(o_acc_out), 32'h0000DE11);
    chk("ovf_x17", 32'(o_overflow), 32'd1);

    // Clear coinciding with an accumulate
    drive_op(8'd2, 8'd3, 1'b0, 1'b1, 16'h0006, 1'b1, 1'b0);
    chk("acc_clr_at_done", 32'(o_acc_out), 32'd6);
    chk("ovf_clr_at_done", 32'(o_overflow), 32'd0);

    // Start re-asserted during CALC with new operands
    drive_op(8'd7, 8'd9, 1'b0, 1'b0, 16'h003F, 1'b0, 1'b1);
    drive_op(8'h7F, 8'h80, 1'b1, 1'b0, 16'hC080, 1'b0, 1'b0);

    // Reset in the middle of CALC
    i_multiplicand = 8'hAA;
    i_multiplier   = 8'h55;
    i_signed_mode  = 1'b0;
    i_acc_en       = 1'b1;
    i_start        = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_all_zero("mid_calc_reset");
    repeat (12) @(negedge clk);
    rst   = 1'b1;
    m_acc = '0;
    m_ovf = 1'b0;
    drive_op(8'd12, 8'd13, 1'b0, 1'b1, 16'h009C, 1'b0, 1'b0);
    chk("acc_after_reset", 32'(o_acc_out), 32'h0000009C);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
